// File: rtl/mem_dump_pkg.sv
// Shared types and constants for the memory dump reader and its skid buffer.
package mem_dump_pkg;

  localparam int DEF_DW     = 32;
  localparam int DEF_AW     = 8;
  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Counters need one extra bit so a full-depth window can be counted to DEPTH.
  function automatic int cnt_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/mem_rd_skid.sv
// Two-entry valid/ready buffer behind a one-cycle-latency memory read port.
// Words flow straight through when empty and the consumer is ready.
module mem_rd_skid
  import mem_dump_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy
);

  logic [DW-1:0]    entry0_q;
  logic [DW-1:0]    entry1_q;
  logic [OCC_W-1:0] count_q;
  logic             pop;

  assign out_valid = (count_q != '0) || in_valid;
  assign out_data  = (count_q != '0) ? entry0_q : (in_valid ? in_data : '0);
  assign occupancy = count_q;
  assign pop       = out_valid && out_ready;

  // The reader's credit scheme guarantees an arriving word always has a free slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= '0;
    end else begin
      case (count_q)
        OCC_W'(0): begin
          if (in_valid && !out_ready) begin
            entry0_q <= in_data;
            count_q  <= OCC_W'(1);
          end
        end
        OCC_W'(1): begin
          if (pop) begin
            if (in_valid) entry0_q <= in_data;
            else          count_q  <= OCC_W'(0);
          end else if (in_valid) begin
            entry1_q <= in_data;
            count_q  <= OCC_W'(2);
          end
        end
        default: begin
          if (pop) begin
            entry0_q <= entry1_q;
            if (in_valid) entry1_q <= in_data;
            else          count_q  <= OCC_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_dump_reader.sv
// Streams a contiguous, wrapping window of a synchronous memory out over valid/ready.
// Reads are credit-limited so no more than two words are ever buffered or in flight.
module mem_dump_reader
  import mem_dump_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          mem_ce,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready
);

  localparam int CW = cnt_width(AW);

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    len_q;
  logic [CW-1:0]    issued_q;
  logic [CW-1:0]    accepted_q;
  logic [AW-1:0]    rd_addr_q;
  logic [AW-1:0]    hold_addr_q;
  logic             inflight_q;
  logic [OCC_W-1:0] occ;
  logic             room;
  logic             handshake;
  logic             last_word;

  mem_rd_skid #(.DW(DW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inflight_q),
    .in_data   (mem_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occ)
  );

  assign handshake = out_valid && out_ready;
  assign room      = (int'(occ) + int'(inflight_q)) < SKID_DEPTH;
  assign last_word = (accepted_q == len_q - CW'(1));
  assign out_last  = out_valid && last_word;
  assign mem_addr  = mem_ce ? rd_addr_q : hold_addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    mem_ce  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = (len == '0) ? ST_DONE : ST_READ;
      end
      ST_READ: begin
        busy = 1'b1;
        if ((issued_q < len_q) && room) begin
          mem_ce = 1'b1;
          if (issued_q == len_q - CW'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // Leave as soon as the final word is taken so done lands one cycle later.
        if ((accepted_q == len_q) || (handshake && last_word)) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q       <= '0;
      issued_q    <= '0;
      accepted_q  <= '0;
      rd_addr_q   <= '0;
      hold_addr_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      inflight_q <= mem_ce;
      if ((state_q == ST_IDLE) && start) begin
        len_q      <= len;
        rd_addr_q  <= base_addr;
        issued_q   <= '0;
        accepted_q <= '0;
      end else begin
        if (mem_ce) begin
          issued_q    <= issued_q + CW'(1);
          rd_addr_q   <= rd_addr_q + AW'(1);
          hold_addr_q <= rd_addr_q;
        end
        if (handshake) accepted_q <= accepted_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: cycle tables, corner sequences and
// randomized dumps compared against a queue of expected memory words.
module tb_mem_dump_reader;

   localparam int DW    = 32;
   localparam int AW    = 8;
   localparam int DEPTH = 1 << AW;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   len;
   logic          busy;
   logic          done;
   logic          mem_ce;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_ready;

   logic [DW-1:0] mem [DEPTH];

   typedef struct {
      logic          ce;
      logic [AW-1:0] addr;
      logic          valid;
      logic [DW-1:0] data;
      logic          last;
      logic          done;
      logic          busy;
   } cycle_vec_t;

   cycle_vec_t basicTab[8];

   int checkCount;
   int passCount;

   // Reference model state: expected words of the current dump, in order
   logic [DW-1:0] expQ[$];
   int            expBase;
   int            expLen;
   int            issuedN;
   int            acceptedN;
   logic          stallPrev;
   logic [DW-1:0] prevData;
   logic          prevLast;

   mem_dump_reader #(.DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .mem_ce    (mem_ce),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port synchronous memory macro: data appears the cycle after mem_ce
   always @(posedge clk) begin
      if (mem_ce) mem_rdata <= mem[mem_addr];
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   // Drive one cycle's inputs just after the edge, then sample at the falling edge
   task automatic applyStimulus(input logic rn, input logic st, input logic [AW-1:0] b,
                                input logic [AW:0] l, input logic rdy);
      @(posedge clk);
      #1;
      rst_n     = rn;
      start     = st;
      base_addr = b;
      len       = l;
      out_ready = rdy;
      @(negedge clk);
   endtask

   function automatic logic readyFor(input int mode, input int cyc);
      case (mode)
         0:       return 1'b1;
         1:       return (cyc % 3) == 0;
         default: return $urandom_range(0, 3) != 0;
      endcase
   endfunction

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
      checkOutput({tag, "_done"}, 64'(done), 64'(0));
      checkOutput({tag, "_mem_ce"}, 64'(mem_ce), 64'(0));
      checkOutput({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
      checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'(0));
      checkOutput({tag, "_out_data"}, 64'(out_data), 64'(0));
      checkOutput({tag, "_out_last"}, 64'(out_last), 64'(0));
   endtask

   task automatic sampleScoreboard();
      if (mem_ce) begin
         checkOutput("credit", 64'((issuedN - acceptedN) < 2), 64'(1));
         checkOutput("rd_addr", 64'(mem_addr), 64'((expBase + issuedN) % DEPTH));
         checkOutput("over_issue", 64'(issuedN < expLen), 64'(1));
         issuedN++;
      end
      if (stallPrev) begin
         checkOutput("stall_valid", 64'(out_valid), 64'(1));
         checkOutput("stall_data", 64'(out_data), 64'(prevData));
         checkOutput("stall_last", 64'(out_last), 64'(prevLast));
      end
      if (out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("extra_word", 64'(1), 64'(0));
         end else begin
            checkOutput("word_data", 64'(out_data), 64'(expQ[0]));
            checkOutput("word_last", 64'(out_last), 64'(acceptedN == expLen - 1));
            void'(expQ.pop_front());
         end
         acceptedN++;
      end
      if (done) checkOutput("done_early", 64'(acceptedN), 64'(expLen));
      stallPrev = out_valid && !out_ready;
      prevData  = out_data;
      prevLast  = out_last;
   endtask

   task automatic runDump(input logic [AW-1:0] b, input logic [AW:0] l, input int mode, input bit midStart);
      bit seenDone;
      int cyc;
      expQ.delete();
      for (int i = 0; i < int'(l); i++) expQ.push_back(mem[(int'(b) + i) % DEPTH]);
      expBase   = int'(b);
      expLen    = int'(l);
      issuedN   = 0;
      acceptedN = 0;
      stallPrev = 1'b0;
      seenDone  = 1'b0;
      applyStimulus(1'b1, 1'b1, b, l, readyFor(mode, 0));
      sampleScoreboard();
      cyc = 1;
      while (!seenDone && cyc < 3000) begin
         if (midStart && cyc == 3) applyStimulus(1'b1, 1'b1, b ^ 8'h55, 9'd7, readyFor(mode, cyc));
         else                      applyStimulus(1'b1, 1'b0, b, l, readyFor(mode, cyc));
         sampleScoreboard();
         if (done) seenDone = 1'b1;
         cyc++;
      end
      checkOutput("done_seen", 64'(seenDone), 64'(1));
      checkOutput("word_count", 64'(acceptedN), 64'(l));
      checkOutput("issue_count", 64'(issuedN), 64'(l));
      applyStimulus(1'b1, 1'b0, b, l, 1'b1);
      checkOutput("done_width", 64'(done), 64'(0));
      checkOutput("busy_after_done", 64'(busy), 64'(0));
   endtask

   initial begin
      bit seen;
      int quiet;
      checkCount = 0;
      passCount  = 0;
      rst_n      = 1'b0;
      start      = 1'b1;
      base_addr  = 8'hAA;
      len        = 9'd5;
      out_ready  = 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 3);

      basicTab[0] = '{1'b0, 8'h00, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0};
      basicTab[1] = '{1'b1, 8'h10, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1};
      basicTab[2] = '{1'b1, 8'h11, 1'b1, 32'h30, 1'b0, 1'b0, 1'b1};
      basicTab[3] = '{1'b1, 8'h12, 1'b1, 32'h33, 1'b0, 1'b0, 1'b1};
      basicTab[4] = '{1'b1, 8'h13, 1'b1, 32'h36, 1'b0, 1'b0, 1'b1};
      basicTab[5] = '{1'b0, 8'h00, 1'b1, 32'h39, 1'b1, 1'b0, 1'b1};
      basicTab[6] = '{1'b0, 8'h00, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1};
      basicTab[7] = '{1'b0, 8'h00, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0};

      $display("[TB] reset with start held high");
      for (int r = 0; r < 3; r++) begin
         applyStimulus(1'b0, 1'b1, 8'hAA, 9'd5, 1'b1);
         checkAllZero("reset");
      end
      applyStimulus(1'b1, 1'b0, 8'hAA, 9'd5, 1'b1);
      checkOutput("release_mem_ce", 64'(mem_ce), 64'(0));
      checkOutput("release_busy", 64'(busy), 64'(0));

      $display("[TB] basic streaming cycle table");
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b1, c == 0, 8'h10, 9'd4, 1'b1);
         checkOutput($sformatf("basic_c%0d_ce", c), 64'(mem_ce), 64'(basicTab[c].ce));
         if (basicTab[c].ce) checkOutput($sformatf("basic_c%0d_addr", c), 64'(mem_addr), 64'(basicTab[c].addr));
         checkOutput($sformatf("basic_c%0d_valid", c), 64'(out_valid), 64'(basicTab[c].valid));
         if (basicTab[c].valid) begin
            checkOutput($sformatf("basic_c%0d_data", c), 64'(out_data), 64'(basicTab[c].data));
            checkOutput($sformatf("basic_c%0d_last", c), 64'(out_last), 64'(basicTab[c].last));
         end
         checkOutput($sformatf("basic_c%0d_done", c), 64'(done), 64'(basicTab[c].done));
         checkOutput($sformatf("basic_c%0d_busy", c), 64'(busy), 64'(basicTab[c].busy));
      end

      $display("[TB] zero-length dump");
      applyStimulus(1'b1, 1'b1, 8'h33, 9'd0, 1'b1);
      applyStimulus(1'b1, 1'b0, 8'h33, 9'd0, 1'b1);
      checkOutput("len0_done", 64'(done), 64'(1));
      checkOutput("len0_busy", 64'(busy), 64'(1));
      checkOutput("len0_ce", 64'(mem_ce), 64'(0));
      checkOutput("len0_valid", 64'(out_valid), 64'(0));
      applyStimulus(1'b1, 1'b0, 8'h33, 9'd0, 1'b1);
      checkOutput("len0_done_end", 64'(done), 64'(0));
      checkOutput("len0_busy_end", 64'(busy), 64'(0));
      checkOutput("len0_ce_end", 64'(mem_ce), 64'(0));

      $display("[TB] start held high re-triggers after done");
      for (int c = 0; c < 7; c++) begin
         applyStimulus(1'b1, 1'b1, 8'h05, 9'd2, 1'b1);
         if (c == 3) begin
            checkOutput("hold_last_data", 64'(out_data), 64'(32'h12));
            checkOutput("hold_last_flag", 64'(out_last), 64'(1));
         end
         if (c == 4) begin
            checkOutput("hold_done", 64'(done), 64'(1));
            checkOutput("hold_busy_done", 64'(busy), 64'(1));
         end
         if (c == 5) begin
            checkOutput("hold_idle_busy", 64'(busy), 64'(0));
            checkOutput("hold_idle_done", 64'(done), 64'(0));
            checkOutput("hold_idle_ce", 64'(mem_ce), 64'(0));
         end
         if (c == 6) begin
            checkOutput("hold_rearm_busy", 64'(busy), 64'(1));
            checkOutput("hold_rearm_ce", 64'(mem_ce), 64'(1));
            checkOutput("hold_rearm_addr", 64'(mem_addr), 64'(8'h05));
         end
      end
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         applyStimulus(1'b1, 1'b0, 8'h05, 9'd2, 1'b1);
         if (done) seen = 1'b1;
      end
      checkOutput("hold_second_done", 64'(seen), 64'(1));
      applyStimulus(1'b1, 1'b0, 8'h05, 9'd2, 1'b1);

      $display("[TB] backpressure, wrap-around and start while busy");
      runDump(8'h40, 9'd6, 1, 1'b0);
      runDump(8'hFE, 9'd4, 0, 1'b0);
      runDump(8'h60, 9'd5, 1, 1'b1);

      $display("[TB] reset in the middle of a dump");
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b1, c == 0, 8'h20, 9'd5, 1'b1);
         if (c == 2) checkOutput("mid_word0", 64'(out_data), 64'(32'h60));
         if (c == 3) checkOutput("mid_word1", 64'(out_data), 64'(32'h63));
      end
      applyStimulus(1'b0, 1'b0, 8'h20, 9'd5, 1'b1);
      applyStimulus(1'b1, 1'b0, 8'h20, 9'd5, 1'b1);
      checkAllZero("midrst");
      quiet = 0;
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b1, 1'b0, 8'h20, 9'd5, 1'b1);
         if (done || busy || mem_ce) quiet++;
      end
      checkOutput("midrst_no_done", 64'(quiet), 64'(0));
      runDump(8'h20, 9'd5, 1, 1'b0);

      $display("[TB] full-depth and randomized dumps");
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      runDump(8'h80, 9'd256, 2, 1'b0);
      for (int k = 0; k < 6; k++) begin
         runDump(AW'($urandom_range(0, DEPTH - 1)), 9'($urandom_range(1, 24)), (k % 2) + 1, 1'b0);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
